// File: rtl/rd_window_gen_if.sv
// Command/window bundle for the DDR3 read-capture window generator.
// Master drives commands and pre/post settings; slave returns ready, windows and busy.
interface rd_window_gen_if #(
   parameter int CNT_W = 6
) ();
   logic [1:0]       pre;
   logic [1:0]       post;
   logic             cmd_valid;
   logic [CNT_W-1:0] cmd_len;
   logic             cmd_ready;
   logic             win;
   logic             win_data;
   logic             busy;

   modport master (
      output pre, post, cmd_valid, cmd_len,
      input  cmd_ready, win, win_data, busy
   );

   modport slave (
      input  pre, post, cmd_valid, cmd_len,
      output cmd_ready, win, win_data, busy
   );
endinterface

// File: rtl/rd_window_gen.sv
// Read-capture window generator: queued bursts -> contiguous win/win_data pulse train.
// Latency: command accepted at E0 is popped at E1 when idle; win rises from E1.
// Backpressure: cmd_ready drops while the command queue is full.
module rd_window_gen #(
   parameter int CNT_W = 6,
   parameter int QLOG2 = 2
) (
   input logic            clk,
   input logic            rst_n,
   rd_window_gen_if.slave bus
);
   localparam int DEPTH = 1 << QLOG2;

   typedef enum logic [1:0] {IDLE, PRE, DATA, POST} state_t;

   state_t           state;
   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] len_q;
   logic [1:0]       post_q;
   logic             win_q;
   logic             win_data_q;

   logic [CNT_W-1:0] mem [DEPTH];
   logic [QLOG2-1:0] wr_ptr;
   logic [QLOG2-1:0] rd_ptr;
   logic [QLOG2:0]   count;
   logic             empty;
   logic             full;
   logic             push;
   logic             pop;
   logic [CNT_W-1:0] head;

   assign empty = (count == '0);
   assign full  = (count == (QLOG2+1)'(DEPTH));
   assign push  = bus.cmd_valid & ~full;
   assign head  = mem[rd_ptr];

   // Pops happen from IDLE, on the last DATA beat (merge), or anywhere in POST (truncate).
   always_comb begin
      pop = 1'b0;
      if (!empty) begin
         case (state)
            IDLE:    pop = 1'b1;
            DATA:    pop = (cnt == '0);
            POST:    pop = 1'b1;
            default: pop = 1'b0;
         endcase
      end
   end

   assign bus.cmd_ready = ~full;
   assign bus.win       = win_q;
   assign bus.win_data  = win_data_q;
   assign bus.busy      = (state != IDLE) | ~empty;

   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr] <= bus.cmd_len;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + QLOG2'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + QLOG2'(1);
         end
         if (push && !pop) begin
            count <= count + (QLOG2+1)'(1);
         end else if (!push && pop) begin
            count <= count - (QLOG2+1)'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         cnt        <= '0;
         len_q      <= '0;
         post_q     <= '0;
         win_q      <= 1'b0;
         win_data_q <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (!empty) begin
                  len_q  <= head;
                  post_q <= bus.post;
                  win_q  <= 1'b1;
                  if (bus.pre != 2'd0) begin
                     state      <= PRE;
                     cnt        <= CNT_W'(bus.pre - 2'd1);
                     win_data_q <= 1'b0;
                  end else begin
                     state      <= DATA;
                     cnt        <= head;
                     win_data_q <= 1'b1;
                  end
               end
            end
            PRE: begin
               if (cnt == '0) begin
                  state      <= DATA;
                  cnt        <= len_q;
                  win_data_q <= 1'b1;
               end else begin
                  cnt <= cnt - CNT_W'(1);
               end
            end
            DATA: begin
               if (cnt == '0) begin
                  if (!empty) begin
                     // Merge: stay in DATA, skip this postamble and the next preamble.
                     len_q  <= head;
                     post_q <= bus.post;
                     cnt    <= head;
                  end else if (post_q != 2'd0) begin
                     state      <= POST;
                     cnt        <= CNT_W'(post_q - 2'd1);
                     win_data_q <= 1'b0;
                  end else begin
                     state      <= IDLE;
                     win_q      <= 1'b0;
                     win_data_q <= 1'b0;
                  end
               end else begin
                  cnt <= cnt - CNT_W'(1);
               end
            end
            POST: begin
               if (!empty) begin
                  state      <= DATA;
                  len_q      <= head;
                  post_q     <= bus.post;
                  cnt        <= head;
                  win_data_q <= 1'b1;
               end else if (cnt == '0) begin
                  state <= IDLE;
                  win_q <= 1'b0;
               end else begin
                  cnt <= cnt - CNT_W'(1);
               end
            end
            default: begin
               state      <= IDLE;
               win_q      <= 1'b0;
               win_data_q <= 1'b0;
            end
         endcase
      end
   end
endmodule
